// File: rtl/pcd_pause_n_pkg.sv
// Shared types and the modified-Miller coding rule for pcd_pause_n_gen.
package pcd_pause_n_pkg;

  // Sequence shapes within one bit period.
  typedef enum logic [1:0] {
    SEQ_X,
    SEQ_Y,
    SEQ_Z
  } miller_seq_t;

  // Frame-level states of the transmitter.
  typedef enum logic [2:0] {
    IDLE,
    SOC,
    DATA,
    EOC0,
    EOC1
  } gen_state_t;

  // Modified-Miller: 1 -> X; 0 -> Y after a 1, otherwise Z.
  function automatic miller_seq_t miller_code(input logic b, input logic prev_one);
    miller_seq_t seq;
    if (b) begin
      seq = SEQ_X;
    end else if (prev_one) begin
      seq = SEQ_Y;
    end else begin
      seq = SEQ_Z;
    end
    return seq;
  endfunction

endpackage

// File: rtl/pcd_pause_n_seq_shaper.sv
// Bit-period timing for pcd_pause_n_gen: tick counter, period-end strobe and
// the registered pause output. The output is computed from next-cycle tick and
// sequence so that a period's pause appears on tick 0 with no extra latency.
module pcd_pause_n_seq_shaper
  import pcd_pause_n_pkg::*;
#(
  parameter int ETU_TICKS = 128,
  parameter int CNT_W     = $clog2(ETU_TICKS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_next,
  input  logic             load,
  input  miller_seq_t      seq_in,
  input  logic [CNT_W-1:0] len_next,
  output logic             period_end,
  output logic             pcd_pause_n
);

  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(ETU_TICKS - 1);
  localparam logic [CNT_W:0]   HALF_W   = (CNT_W + 1)'(ETU_TICKS / 2);

  logic [CNT_W-1:0] tick_reg;
  logic [CNT_W-1:0] tick_next;
  miller_seq_t      seq_reg;
  miller_seq_t      seq_next;
  logic [CNT_W:0]   tick_w;
  logic [CNT_W:0]   len_w;
  logic             low_next;

  assign period_end = (tick_reg == TICK_MAX);

  // Next tick/sequence and whether the line must be in a pause next cycle.
  always_comb begin
    seq_next  = load ? seq_in : seq_reg;
    tick_next = (run_next && !load) ? tick_reg + CNT_W'(1) : '0;
    tick_w    = {1'b0, tick_next};
    len_w     = {1'b0, len_next};
    low_next  = 1'b0;
    if (run_next) begin
      case (seq_next)
        SEQ_Z:   low_next = (tick_w < len_w);
        SEQ_X:   low_next = (tick_w >= HALF_W) && (tick_w < HALF_W + len_w);
        default: low_next = 1'b0;
      endcase
    end
  end

  // Counter, current sequence and the registered line output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_reg    <= '0;
      seq_reg     <= SEQ_Y;
      pcd_pause_n <= 1'b1;
    end else begin
      tick_reg    <= tick_next;
      seq_reg     <= seq_next;
      pcd_pause_n <= !low_next;
    end
  end

endmodule

// File: rtl/pcd_pause_n_gen.sv
// PCD-side ISO 14443A modified-Miller pause generator. Frames a valid/ready bit
// stream with SOC and EOC. Optional build macro PCD_PAUSE_N_GEN_RUNTIME_PAUSE_EN
// adds a pause_len input sampled per frame in place of PAUSE_TICKS.
module pcd_pause_n_gen
  import pcd_pause_n_pkg::*;
#(
  parameter int ETU_TICKS   = 128,
  parameter int PAUSE_TICKS = 32,
  parameter int CNT_W       = $clog2(ETU_TICKS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_data,
  input  logic             tx_last,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             busy,
  output logic             underrun,
  output logic             pcd_pause_n
`ifdef PCD_PAUSE_N_GEN_RUNTIME_PAUSE_EN
  ,
  input  logic [CNT_W-1:0] pause_len
`endif
);

  localparam logic [CNT_W-1:0] PAUSE_DEF = CNT_W'(PAUSE_TICKS);

  gen_state_t       state;
  logic             bit_reg;
  logic             last_reg;
  logic [CNT_W-1:0] len_reg;
  logic [CNT_W-1:0] len_sel;
  logic [CNT_W-1:0] len_next;
  logic             period_end;
  logic             hs;
  logic             prev_one;
  logic             run_next;
  logic             load;
  miller_seq_t      seq_up;

`ifdef PCD_PAUSE_N_GEN_RUNTIME_PAUSE_EN
  // Out-of-range runtime lengths fall back to the default pause.
  assign len_sel = ((pause_len == '0) ||
                    ({1'b0, pause_len} >= (CNT_W + 1)'(ETU_TICKS / 2))) ? PAUSE_DEF : pause_len;
`else
  assign len_sel = PAUSE_DEF;
`endif

  assign busy     = (state != IDLE);
  assign tx_ready = rst_n && ((state == IDLE) || ((state == DATA) && period_end && !last_reg));
  assign underrun = rst_n && (state == DATA) && period_end && !last_reg && !tx_valid;
  assign hs       = tx_valid && tx_ready;
  // The current period carries a logic 1 only while a held 1 is being sent;
  // SOC and EOC0 both count as 0 for the following period.
  assign prev_one = (state == DATA) && bit_reg;
  assign len_next = (state == IDLE) ? len_sel : len_reg;

  // Decide whether a new period starts next cycle and which sequence it uses.
  always_comb begin
    run_next = (state != IDLE);
    load     = 1'b0;
    seq_up   = SEQ_Y;
    case (state)
      IDLE: begin
        run_next = hs;
        load     = hs;
        seq_up   = SEQ_Z;
      end
      SOC: begin
        load   = period_end;
        seq_up = miller_code(bit_reg, 1'b0);
      end
      DATA: begin
        load   = period_end;
        seq_up = hs ? miller_code(tx_data, prev_one) : miller_code(1'b0, prev_one);
      end
      EOC0: begin
        load   = period_end;
        seq_up = SEQ_Y;
      end
      EOC1: begin
        run_next = !period_end;
      end
      default: run_next = 1'b0;
    endcase
    if (!rst_n) begin
      run_next = 1'b0;
      load     = 1'b0;
    end
  end

  // Frame FSM: handshake capture and period sequencing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_reg  <= 1'b0;
      last_reg <= 1'b0;
      len_reg  <= PAUSE_DEF;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            state    <= SOC;
            bit_reg  <= tx_data;
            last_reg <= tx_last;
            len_reg  <= len_sel;
          end
        end
        SOC: begin
          if (period_end) state <= DATA;
        end
        DATA: begin
          if (period_end) begin
            if (hs) begin
              bit_reg  <= tx_data;
              last_reg <= tx_last;
            end else begin
              state <= EOC0;
            end
          end
        end
        EOC0: begin
          if (period_end) state <= EOC1;
        end
        EOC1: begin
          if (period_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  pcd_pause_n_seq_shaper #(
    .ETU_TICKS (ETU_TICKS),
    .CNT_W     (CNT_W)
  ) u_shaper (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_next    (run_next),
    .load        (load),
    .seq_in      (seq_up),
    .len_next    (len_next),
    .period_end  (period_end),
    .pcd_pause_n (pcd_pause_n)
  );

endmodule

// File: tb/tb_pcd_pause_n_gen.sv
// Scoreboard bench for pcd_pause_n_gen: frames are expanded into expected pause
// windows and frame statistics; a negedge monitor compares what the DUT emits.
module tb_pcd_pause_n_gen;

  localparam int ETU  = 128;
  localparam int PT   = 32;
  localparam int HALF = ETU / 2;
  localparam int CW   = $clog2(ETU);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_data = 1'b0;
  logic tx_last = 1'b0;
  logic tx_valid = 1'b0;
  logic tx_ready, busy, underrun, pcd_pause_n;
`ifdef PCD_PAUSE_N_GEN_RUNTIME_PAUSE_EN
  logic [CW-1:0] pause_len = CW'(PT);
`endif

  always #5 clk = ~clk;

  pcd_pause_n_gen #(
    .ETU_TICKS   (ETU),
    .PAUSE_TICKS (PT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_data     (tx_data),
    .tx_last     (tx_last),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .underrun    (underrun),
    .pcd_pause_n (pcd_pause_n)
`ifdef PCD_PAUSE_N_GEN_RUNTIME_PAUSE_EN
    ,
    .pause_len   (pause_len)
`endif
  );

  typedef struct { int start; int len; } pause_t;
  typedef struct { int busy_len; int n_ready; int ur_off; int n_ur; int n_pauses; bit b2b; } frame_t;

  pause_t exp_p[$];
  frame_t exp_f[$];
  int  tests = 0;
  int  fails = 0;
  bit  mon_en = 1'b0;
  int  cyc = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: frame = SOC(Z), coded data bits, EOC logic 0, then Y.
  task automatic model_frame(input bit bits[$], input int nsent, input bit ur,
                             input int plen, input bit b2b);
    byte    syms[$];
    bit     prev;
    frame_t f;
    int     np;
    syms.push_back("Z");
    prev = 1'b0;
    for (int i = 0; i < nsent; i++) begin
      if (bits[i]) syms.push_back("X");
      else         syms.push_back(prev ? "Y" : "Z");
      prev = bits[i];
    end
    syms.push_back(prev ? "Y" : "Z");
    syms.push_back("Y");
    np = 0;
    for (int k = 0; k < syms.size(); k++) begin
      int base;
      base = 1 + k * ETU;
      if (syms[k] == "Z") begin exp_p.push_back('{base, plen}); np++; end
      if (syms[k] == "X") begin exp_p.push_back('{base + HALF, plen}); np++; end
    end
    f.busy_len = (nsent + 3) * ETU;
    f.n_ready  = ur ? nsent + 1 : nsent;
    f.ur_off   = ur ? (nsent + 1) * ETU : -1;
    f.n_ur     = ur ? 1 : 0;
    f.n_pauses = np;
    f.b2b      = b2b;
    exp_f.push_back(f);
  endtask

  task automatic wait_hs(input int budget);
    int k;
    bit got;
    k = 0;
    got = 1'b0;
    while (!got && k < budget) begin
      @(negedge clk);
      got = tx_ready;
      @(posedge clk);
      #1;
      k++;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL handshake_timeout: tx_ready not seen within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", budget);
    end
    @(posedge clk);
    #1;
  endtask

  // Issue one frame; ur_at >= 0 withholds the bit at that index (underrun).
  task automatic run_frame(input bit bits[$], input int ur_at, input bit b2b, input bit keep_valid);
    int n, nsent, plen;
    bit ur;
    n     = bits.size();
    ur    = (ur_at >= 0);
    nsent = ur ? ur_at : n;
`ifdef PCD_PAUSE_N_GEN_RUNTIME_PAUSE_EN
    case ($urandom_range(0, 3))
      0: pause_len = CW'(20);
      1: pause_len = CW'(64);
      2: pause_len = CW'(0);
      default: pause_len = CW'($urandom_range(1, ETU - 1));
    endcase
    plen = (pause_len == 0 || int'(pause_len) >= HALF) ? PT : int'(pause_len);
`else
    plen = PT;
`endif
    model_frame(bits, nsent, ur, plen, b2b);
    for (int i = 0; i < nsent; i++) begin
      tx_valid = 1'b1;
      tx_data  = bits[i];
      tx_last  = !ur && (i == n - 1);
      wait_hs(10 * ETU);
`ifdef PCD_PAUSE_N_GEN_RUNTIME_PAUSE_EN
      if (i == 0) pause_len = CW'($urandom_range(0, ETU - 1));
`endif
    end
    if (!keep_valid) begin
      tx_valid = 1'b0;
      tx_data  = 1'b0;
      tx_last  = 1'b0;
    end
  endtask

  // Monitor: pause windows, ready/underrun activity and busy span per frame.
  int f_start = 0, last_fall = -100, p_start_abs = 0;
  int rdy_cnt = 0, ur_cnt = 0, ur_off = -1, p_cnt = 0;
  bit prev_p = 1'b1, prev_b = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (!busy && prev_b) begin
        frame_t e;
        last_fall = cyc;
        check("frame_queue", int'(exp_f.size() > 0), 1);
        if (exp_f.size() > 0) begin
          e = exp_f.pop_front();
          check("busy_len", cyc - 1 - f_start, e.busy_len);
          check("ready_pulses", rdy_cnt, e.n_ready);
          check("underrun_count", ur_cnt, e.n_ur);
          check("underrun_offset", ur_off, e.ur_off);
          check("pause_count", p_cnt, e.n_pauses);
          $display("[TB] frame start=%0d busy=%0d ready=%0d underrun_off=%0d pauses=%0d",
                   f_start, cyc - 1 - f_start, rdy_cnt, ur_off, p_cnt);
        end
      end
      if (tx_valid && tx_ready && !busy) begin
        if (exp_f.size() > 0 && exp_f[0].b2b) check("b2b_gap", cyc - last_fall, 0);
        f_start = cyc;
        rdy_cnt = 1;
        ur_cnt  = 0;
        ur_off  = -1;
        p_cnt   = 0;
      end
      if (busy && tx_ready) rdy_cnt++;
      if (underrun) begin
        ur_cnt++;
        ur_off = cyc - f_start;
      end
      if (!pcd_pause_n && prev_p) p_start_abs = cyc;
      if (pcd_pause_n && !prev_p) begin
        pause_t e;
        p_cnt++;
        check("pause_queue", int'(exp_p.size() > 0), 1);
        if (exp_p.size() > 0) begin
          e = exp_p.pop_front();
          check("pause_start", p_start_abs - f_start, e.start);
          check("pause_len", cyc - p_start_abs, e.len);
        end
      end
    end
    prev_p = pcd_pause_n;
    prev_b = busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit q[$];
    bit keep, prev_keep;
    int n, ur_at;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pause_n", pcd_pause_n, 1);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_tx_ready", tx_ready, 1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Single-bit frame {1}
    q.delete(); q.push_back(1'b1);
    run_frame(q, -1, 1'b0, 1'b0);
    wait_idle(8 * ETU);

    // Frame {1,0}
    q.delete(); q.push_back(1'b1); q.push_back(1'b0);
    run_frame(q, -1, 1'b0, 1'b0);
    wait_idle(8 * ETU);

    // Underrun: 3-bit frame, second bit withheld
    q.delete(); q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1);
    run_frame(q, 1, 1'b0, 1'b0);
    wait_idle(8 * ETU);

    // Back-to-back 8-bit frames with tx_valid held
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(1'($urandom_range(0, 1)));
    run_frame(q, -1, 1'b0, 1'b1);
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(1'($urandom_range(0, 1)));
    run_frame(q, -1, 1'b1, 1'b0);
    wait_idle(16 * ETU);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of an X pause
    mon_en   = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 1'b1;
    tx_last  = 1'b0;
    wait_hs(4);
    tx_last = 1'b1;
    repeat (199) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("pause_before_reset", pcd_pause_n, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_pause_n", pcd_pause_n, 1);
    check("abort_busy", busy, 0);
    check("abort_tx_ready", tx_ready, 0);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("release_tx_ready", tx_ready, 1);
    check("release_busy", busy, 0);
    check("release_pause_n", pcd_pause_n, 1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Randomised frames, some truncated, some back-to-back
    prev_keep = 1'b0;
    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(1, 8);
      ur_at = (!prev_keep && n > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : -1;
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(1'($urandom_range(0, 1)));
      keep = (ur_at < 0) && (f < 9) && ($urandom_range(0, 1) == 1);
      run_frame(q, ur_at, prev_keep, keep);
      if (!keep) begin
        wait_idle(16 * ETU);
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      prev_keep = keep;
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pauses_left", exp_p.size(), 0);
    check("frames_left", exp_f.size(), 0);
    check("final_pause_n", pcd_pause_n, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pcd_pause_n_gen.md
Name: pcd_pause_n_gen

Overview:
- Parametrised PCD-side transmitter that drives pcd_pause_n with ISO/IEC 14443A Type A modified-Miller pause sequences.
- Bits arrive over a valid/ready stream. The block frames them with Start of Communication (SOC) and End of Communication (EOC) and produces cycle-accurate pauses.
- Bit period and pause length are parameters.
- Sits in the PCD BFM/testbench path; its output feeds the pcd_pause_n signal seen by the PICC analogue/digital front end.

Parameters:
- ETU_TICKS, 128, clk cycles per bit period (13.56 MHz carrier → 106 kbit/s); even, >= 8.
- PAUSE_TICKS, 32, pause length (pcd_pause_n low) in clk cycles; 1 <= PAUSE_TICKS < ETU_TICKS/2.
- CNT_W, $clog2(ETU_TICKS), width of the in-period tick counter.

Ports:
- clk  input  1  PCD clock
- rst_n  input  1  synchronous active-low reset
- tx_data  input  1  data bit, LSB-first order is the producer's responsibility
- tx_last  input  1  marks the final bit of the frame
- tx_valid  input  1  tx_data/tx_last valid
- tx_ready  output  1  block accepts the bit this cycle
- busy  output  1  frame in progress (SOC through final EOC Y)
- underrun  output  1  one-cycle pulse: next bit needed but tx_valid low
- pcd_pause_n  output  1  registered; 0 = pause (carrier off)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset: pcd_pause_n=1, tx_ready=0 during reset, busy=0, underrun=0, state=IDLE, tick=0, prev_one=0. rst_n low mid-frame aborts immediately: pcd_pause_n=1 from the next edge, no EOC emitted.
- Sequences, indexed by tick 0..ETU_TICKS-1 within a bit period:
  - Z: low for tick < PAUSE_TICKS.
  - X: low for ETU_TICKS/2 <= tick < ETU_TICKS/2+PAUSE_TICKS.
  - Y: never low.
- Coding:
  - Logic 1 → X.
  - Logic 0 → Y if the previous bit was 1, else Z.
  - SOC = Z, and counts as previous bit 0.
  - EOC = logic 0 (coded per the rule above) followed by Y.
- States: IDLE → SOC → DATA → EOC0 → EOC1 → IDLE.
  - IDLE: tx_ready=1, pcd_pause_n=1. A handshake (tx_valid & tx_ready) latches bit/last; the next cycle enters SOC with tick=0, busy=1.
  - SOC: one period of Z → DATA.
  - DATA: one period per held bit. At tick==ETU_TICKS-1, if the held bit is not last, tx_ready=1 for that single cycle.
    - Handshake → load the new bit; the next period starts with no gap.
    - No tx_valid → underrun pulse, go to EOC0 (frame truncated, properly terminated).
    - Last bit completes → EOC0.
  - EOC0: logic 0 per the coding rule. EOC1: Y. At the end of EOC1 → IDLE, busy=0 on the following cycle.
- tx_ready is never high outside IDLE and the final DATA tick.
- tx_valid held with tx_ready low has no effect.
- Latency:
  - pcd_pause_n first goes low exactly 1 cycle after the IDLE handshake (SOC tick 0), due to the registered output.
  - Total busy time is (N+3)*ETU_TICKS cycles for an N-bit frame.
- prev_one is updated at each period boundary from the bit just sent; it is cleared on IDLE entry.
- Back-to-back frames: at least one IDLE cycle between frames; a new frame is accepted on the first IDLE cycle.

Optional Feature:
- Macro: PCD_PAUSE_N_GEN_RUNTIME_PAUSE_EN.
- Defined: adds input pause_len [CNT_W-1:0].
  - Sampled at the IDLE handshake and held for the whole frame; replaces PAUSE_TICKS.
  - A sampled value of 0 or >= ETU_TICKS/2 is clamped to PAUSE_TICKS.
- Undefined: port absent; PAUSE_TICKS is fixed.

Decomposition:
- Package pcd_pause_n_pkg:
  - miller_seq_t enum {SEQ_X, SEQ_Y, SEQ_Z}.
  - gen_state_t enum {IDLE, SOC, DATA, EOC0, EOC1}.
  - Function miller_code(bit, prev_one) returning miller_seq_t.
- Sub-module pcd_pause_n_seq_shaper: owns the tick counter and period-end strobe; maps (miller_seq_t, tick, pause length) to registered pcd_pause_n.
- The top level holds the FSM and handshake.

Test Plan (ETU_TICKS=128, PAUSE_TICKS=32):
- Frame {1,last}: low at cycles 1-32 (SOC Z) and 193-224 (X); EOC 0 after 1 → Y, then Y; busy high for 512 cycles; pcd_pause_n=1 afterwards.
- Frame {1,0,last}: SOC Z, X, Y (0 after 1), EOC Z (0 after 0), Y; exactly 3 pauses, third starting at cycle 385.
- Underrun: 3-bit frame with tx_valid dropped at bit 2's ready cycle → underrun=1 for one cycle at cycle 256; EOC follows immediately; busy drops after cycle 512.
- Reset mid-X-pause (rst_n low at cycle 200): pcd_pause_n=1 at cycle 201, busy=0, tx_ready=1 once rst_n is released; a new frame then starts cleanly.
- Back-to-back: two 8-bit frames with tx_valid held; the second SOC pause starts 1 cycle after the first frame's busy falls; tx_ready pulses exactly 8 times per frame.
- With PCD_PAUSE_N_GEN_RUNTIME_PAUSE_EN:
  - pause_len=20 → every pause is 20 cycles.
  - pause_len=64 → clamped to 32.
  - Changing pause_len mid-frame has no effect until the next frame.
